data_memory: RTL and testbench

//  SPU local store for the odd-pipe memory stage (stage 7) of the dual-issue 128-bit pipeline.
//  - Holds DEPTH quadwords (16 bytes each).
//  - Serves loads combinationally, so the stage-7 register-or-memory mux can capture the data in the same cycle.
//  - Performs stores on the clock edge.
//  - Acts only when the stage-7 odd-pipe unit ID selects the load/store unit.

---
 rtl/data_memory.sv | 57 +++++
 tb/tb_data_memory.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Odd-pipe local store: DEPTH quadwords, combinational load, clocked store.
// Only the load/store unit ID triggers an access; reset clears the whole array.
module data_memory #(
   parameter int         DEPTH      = 2048,
   parameter int         ADDR_BITS  = 11,
   parameter logic [2:0] LS_UNIT_ID = 3'd7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] address,
   input  logic [127:0] store_data,
   input  logic [2:0]   unit_id,
   input  logic         reg_write_enable,
   output logic [127:0] read_data
);

   // Effective address lives in the preferred slot (bits 127:96).
   // Its low nibble is the byte offset and is dropped.
   localparam int IDX_LSB = 96 + 4;

   logic [127:0]         mem_q [DEPTH];
   logic [ADDR_BITS-1:0] index;
   logic                 ls_sel;
   logic                 load_en;
   logic                 store_en;
   logic                 unused_addr_bits;

   assign index = address[IDX_LSB+ADDR_BITS-1:IDX_LSB];

   // Bits above the index wrap away, and the other slots are not part of the address.
   // Reducing them to one bit marks them as intentionally unused.
   assign unused_addr_bits = ^{address[127:IDX_LSB+ADDR_BITS], address[IDX_LSB-1:0]};

   // Decode the operation and drive the zero-latency load path.
   // An X unit_id fails the equality test, so it cannot start a write.
   always_comb begin
      ls_sel    = (unit_id == LS_UNIT_ID);
      load_en   = ls_sel && reg_write_enable;
      store_en  = ls_sel && !reg_write_enable;
      read_data = '0;
      if (load_en && !reset) begin
         read_data = mem_q[index];
      end
   end

   // Array storage: an asynchronous clear, otherwise a full-quadword store on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (store_en) begin
         mem_q[index] <= store_data;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory.
// Stimulus pushes the expected read_data for each cycle; a negedge monitor pops and compares.
module tb_data_memory;

   localparam int DEPTH = 2048;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] address;
   logic [127:0] store_data;
   logic [2:0]   unit_id;
   logic         reg_write_enable;
   logic [127:0] read_data;

   typedef struct {
      logic [127:0] exp;
      string        name;
   } exp_t;

   exp_t         exp_q[$];
   logic [127:0] ref_mem [DEPTH];
   int           errors = 0;
   int           checks = 0;

   data_memory dut (
      .clk              (clk),
      .reset            (reset),
      .address          (address),
      .store_data       (store_data),
      .unit_id          (unit_id),
      .reg_write_enable (reg_write_enable),
      .read_data        (read_data)
   );

   always #5 clk = ~clk;

   // The quadword slot selected by a byte address, wrapping modulo DEPTH*16 bytes.
   function automatic int qidx(input logic [31:0] ea);
      return int'((ea / 32'd16) % DEPTH);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic push_exp(input logic [127:0] v, input string nm);
      exp_t e;
      e.exp  = v;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // One operation per cycle.
   // The lower 96 address bits are random filler, so they must not affect the access.
   task automatic issue(input logic [2:0] uid, input logic rwe, input logic [31:0] ea,
                        input logic [127:0] d, input string nm);
      @(posedge clk);
      #1;
      unit_id          = uid;
      reg_write_enable = rwe;
      address          = {ea, $urandom, $urandom, $urandom};
      store_data       = d;
      if (uid == 3'd7 && rwe) begin
         push_exp(ref_mem[qidx(ea)], nm);
      end else begin
         if (uid == 3'd7 && !rwe) ref_mem[qidx(ea)] = d;
         push_exp('0, nm);
      end
   endtask

   task automatic sweep(input string nm);
      for (int i = 0; i < DEPTH; i++) begin
         issue(3'd7, 1'b1, 32'(i * 16), '0, nm);
      end
   endtask

   // Monitor: compare one expected value per cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            checks++;
            if (read_data !== e.exp) begin
               errors++;
               $display("FAIL %s: read_data=%h expected=%h", e.name, read_data, e.exp);
            end
         end
      end
   end

   initial begin
      automatic logic [127:0] pat = 128'h0123456789ABCDEF0123456789ABCDEF;
      automatic logic [127:0] d;

      reset            = 1'b1;
      unit_id          = 3'd0;
      reg_write_enable = 1'b0;
      address          = '0;
      store_data       = '0;
      clear_model();
      #12 reset = 1'b0;

      // 1: reset contents
      issue(3'd7, 1'b1, 32'h0000_0000, '0, "reset_load0");
      sweep("reset_sweep");

      // 2: store a pattern at 0x40, then load it back; only index 4 changes
      issue(3'd7, 1'b0, 32'h0000_0040, pat, "store40_cycle");
      issue(3'd7, 1'b1, 32'h0000_0040, '0, "load40");
      sweep("after_store40_sweep");

      // 3: the byte offset is ignored, and high address bits wrap
      d = rand128();
      issue(3'd7, 1'b0, 32'h0000_0045, d, "store45_cycle");
      issue(3'd7, 1'b1, 32'h0000_004F, '0, "load4F");
      issue(3'd7, 1'b1, 32'h0000_8040, '0, "load8040_wrap");
      issue(3'd7, 1'b1, 32'hFFFF_8047, '0, "loadFFFF8047_wrap");

      // 4: other units neither write nor read
      issue(3'd3, 1'b0, 32'h0000_0040, rand128(), "unit3_store");
      issue(3'd3, 1'b1, 32'h0000_0040, '0, "unit3_load");
      issue(3'bxxx, 1'b0, 32'h0000_0040, rand128(), "unitx_store");
      issue(3'd6, 1'b0, 32'h0000_0040, rand128(), "unit6_store");
      issue(3'd7, 1'b1, 32'h0000_0040, '0, "load40_unchanged");

      // 5: back-to-back store then load to the same index
      for (int k = 0; k < 4; k++) begin
         d = rand128();
         issue(3'd7, 1'b0, 32'(32'h100 + k * 16), d, "b2b_store_cycle");
         issue(3'd7, 1'b1, 32'(32'h100 + k * 16), '0, "b2b_load");
      end
      issue(3'd7, 1'b1, 32'h0000_0000, '0, "top_entry_load");
      issue(3'd7, 1'b0, 32'h0000_7FF0, pat, "last_entry_store");
      issue(3'd7, 1'b1, 32'h0000_7FF0, '0, "last_entry_load");

      // Randomized traffic over a small window, so stores and loads collide often
      for (int n = 0; n < 600; n++) begin
         automatic logic [2:0]  uid = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd7;
         automatic logic        rwe = 1'($urandom_range(0, 1));
         automatic logic [31:0] ea  = ($urandom << 15) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
         issue(uid, rwe, ea, rand128(), "random_op");
      end

      // 6: asynchronous reset between edges after several stores
      for (int k = 20; k < 24; k++) issue(3'd7, 1'b0, 32'(k * 16), rand128(), "pre_reset_store");
      issue(3'd7, 1'b1, 32'(20 * 16), '0, "pre_reset_load");
      @(posedge clk);
      #1;
      unit_id          = 3'd7;
      reg_write_enable = 1'b1;
      address          = {32'(20 * 16), 96'h0};
      #2;
      reset = 1'b1;
      clear_model();
      #1;
      reg_write_enable = 1'b0;
      address          = {32'(25 * 16), 96'h0};
      store_data       = rand128();
      push_exp('0, "async_reset_readback");
      @(posedge clk);
      #1;
      push_exp('0, "reset_held_store");
      #2;
      reset   = 1'b0;
      unit_id = 3'd0;
      issue(3'd7, 1'b1, 32'(25 * 16), '0, "aborted_store_load");
      sweep("post_reset_sweep");

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: pending=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
